// File: rtl/blob_stats.sv
// Per-label area / centroid accumulator; on frame end prunes small blobs and emits one record per blob.
// Latency: pixel -> table 1 cycle; per emitted blob 1 scan + 26 divide + 1 emit cycles.
// Backpressure: record held stable while blob_ready_in is low; input ignored while busy. BLOB_BBOX_EN adds bounding boxes.
module blob_stats #(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 180,
    parameter int MAX_LABELS = 16,
    parameter int MIN_AREA   = 50
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [7:0]  label_in,
    input  logic [10:0] x_in,
    input  logic [9:0]  y_in,
    input  logic        valid_in,
    input  logic        frame_done_in,
    output logic        busy_out,
    output logic        blob_valid_out,
    input  logic        blob_ready_in,
    output logic [7:0]  blob_label_out,
    output logic [8:0]  blob_x_out,
    output logic [7:0]  blob_y_out,
    output logic [15:0] blob_area_out,
    output logic        frame_summary_out,
    output logic [7:0]  num_blobs_out,
    output logic        overflow_out
`ifdef BLOB_BBOX_EN
    ,
    output logic [8:0]  blob_xmin_out,
    output logic [8:0]  blob_xmax_out,
    output logic [7:0]  blob_ymin_out,
    output logic [7:0]  blob_ymax_out
`endif
);

    localparam int              IW       = $clog2(MAX_LABELS);
    localparam logic [IW-1:0]   LAST_IDX = IW'(MAX_LABELS - 1);
    localparam logic [7:0]      LBL_LIM  = 8'(MAX_LABELS);
    localparam logic [10:0]     X_LIM    = 11'(WIDTH);
    localparam logic [9:0]      Y_LIM    = 10'(HEIGHT);
    localparam logic [15:0]     AREA_MIN = 16'(MIN_AREA);

    typedef enum logic [2:0] {ACCUM, SCAN, DIVIDE, EMIT, DONE, CLEAR} state_t;

    state_t                  state;
    logic [15:0]             area [MAX_LABELS];
    logic [25:0]             xsum [MAX_LABELS];
    logic [25:0]             ysum [MAX_LABELS];
    logic [MAX_LABELS-1:0]   present;
`ifdef BLOB_BBOX_EN
    logic [8:0]              xmin [MAX_LABELS];
    logic [8:0]              xmax [MAX_LABELS];
    logic [7:0]              ymin [MAX_LABELS];
    logic [7:0]              ymax [MAX_LABELS];
`endif

    logic [IW-1:0]           idx;
    logic [4:0]              cnt;
    logic [7:0]              blob_cnt;
    logic [25:0]             xq, yq;
    logic [15:0]             xr, yr;
    logic [15:0]             dv;

    logic                    pix_ok;
    logic [IW-1:0]           pix_lbl;
    logic [16:0]             dv_ext, xr_sh, yr_sh;
    logic                    x_ge, y_ge;
    logic [15:0]             xr_nx, yr_nx;
    logic [25:0]             xq_nx, yq_nx;

    assign pix_lbl = label_in[IW-1:0];
    assign pix_ok  = valid_in && (state == ACCUM) && (label_in != 8'd0) &&
                     (label_in < LBL_LIM) && (x_in < X_LIM) && (y_in < Y_LIM);

    // Restoring divider step: dividend register shifts out MSB-first and fills with quotient bits.
    always_comb begin
        dv_ext = {1'b0, dv};
        xr_sh  = {xr, xq[25]};
        yr_sh  = {yr, yq[25]};
        x_ge   = (xr_sh >= dv_ext);
        y_ge   = (yr_sh >= dv_ext);
        xr_nx  = x_ge ? 16'(xr_sh - dv_ext) : xr_sh[15:0];
        yr_nx  = y_ge ? 16'(yr_sh - dv_ext) : yr_sh[15:0];
        xq_nx  = {xq[24:0], x_ge};
        yq_nx  = {yq[24:0], y_ge};
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || state == CLEAR) begin
            for (int i = 0; i < MAX_LABELS; i++) begin
                area[i]    <= '0;
                xsum[i]    <= '0;
                ysum[i]    <= '0;
                present[i] <= 1'b0;
`ifdef BLOB_BBOX_EN
                xmin[i]    <= 9'(WIDTH - 1);
                xmax[i]    <= '0;
                ymin[i]    <= 8'(HEIGHT - 1);
                ymax[i]    <= '0;
`endif
            end
        end else if (pix_ok) begin
            if (area[pix_lbl] != 16'hFFFF)
                area[pix_lbl] <= area[pix_lbl] + 16'd1;
            xsum[pix_lbl]    <= xsum[pix_lbl] + 26'(x_in);
            ysum[pix_lbl]    <= ysum[pix_lbl] + 26'(y_in);
            present[pix_lbl] <= 1'b1;
`ifdef BLOB_BBOX_EN
            if (x_in[8:0] < xmin[pix_lbl]) xmin[pix_lbl] <= x_in[8:0];
            if (x_in[8:0] > xmax[pix_lbl]) xmax[pix_lbl] <= x_in[8:0];
            if (y_in[7:0] < ymin[pix_lbl]) ymin[pix_lbl] <= y_in[7:0];
            if (y_in[7:0] > ymax[pix_lbl]) ymax[pix_lbl] <= y_in[7:0];
`endif
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state             <= ACCUM;
            idx               <= '0;
            cnt               <= '0;
            blob_cnt          <= '0;
            xq                <= '0;
            yq                <= '0;
            xr                <= '0;
            yr                <= '0;
            dv                <= '0;
            busy_out          <= 1'b0;
            blob_valid_out    <= 1'b0;
            blob_label_out    <= '0;
            blob_x_out        <= '0;
            blob_y_out        <= '0;
            blob_area_out     <= '0;
            frame_summary_out <= 1'b0;
            num_blobs_out     <= '0;
            overflow_out      <= 1'b0;
`ifdef BLOB_BBOX_EN
            blob_xmin_out     <= '0;
            blob_xmax_out     <= '0;
            blob_ymin_out     <= '0;
            blob_ymax_out     <= '0;
`endif
        end else begin
            case (state)
                ACCUM: begin
                    if (valid_in && label_in >= LBL_LIM)
                        overflow_out <= 1'b1;
                    if (frame_done_in) begin
                        state    <= SCAN;
                        idx      <= IW'(1);
                        busy_out <= 1'b1;
                    end
                end
                SCAN: begin
                    if (present[idx] && area[idx] >= AREA_MIN) begin
                        xq    <= xsum[idx];
                        yq    <= ysum[idx];
                        xr    <= '0;
                        yr    <= '0;
                        dv    <= area[idx];
                        cnt   <= '0;
                        state <= DIVIDE;
                    end else if (idx == LAST_IDX) begin
                        state             <= DONE;
                        frame_summary_out <= 1'b1;
                        num_blobs_out     <= blob_cnt;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DIVIDE: begin
                    xq  <= xq_nx;
                    yq  <= yq_nx;
                    xr  <= xr_nx;
                    yr  <= yr_nx;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd25) begin
                        // Centroids are below WIDTH/HEIGHT, so the low quotient bits carry the full value.
                        state          <= EMIT;
                        blob_valid_out <= 1'b1;
                        blob_label_out <= 8'(idx);
                        blob_x_out     <= xq_nx[8:0];
                        blob_y_out     <= yq_nx[7:0];
                        blob_area_out  <= dv;
`ifdef BLOB_BBOX_EN
                        blob_xmin_out  <= xmin[idx];
                        blob_xmax_out  <= xmax[idx];
                        blob_ymin_out  <= ymin[idx];
                        blob_ymax_out  <= ymax[idx];
`endif
                    end
                end
                EMIT: begin
                    if (blob_ready_in) begin
                        blob_valid_out <= 1'b0;
                        blob_cnt       <= blob_cnt + 8'd1;
                        if (idx == LAST_IDX) begin
                            state             <= DONE;
                            frame_summary_out <= 1'b1;
                            num_blobs_out     <= blob_cnt + 8'd1;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= SCAN;
                        end
                    end
                end
                DONE: begin
                    frame_summary_out <= 1'b0;
                    num_blobs_out     <= '0;
                    state             <= CLEAR;
                end
                CLEAR: begin
                    overflow_out <= 1'b0;
                    busy_out     <= 1'b0;
                    blob_cnt     <= '0;
                    state        <= ACCUM;
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_blob_stats.sv
// Scoreboard bench for blob_stats: reference model computes expected records per frame, monitor pops and compares.
module tb_blob_stats;

    localparam int ML = 16;

    logic        clk_in;
    logic        rst_in;
    logic [7:0]  label_in;
    logic [10:0] x_in;
    logic [9:0]  y_in;
    logic        valid_in;
    logic        frame_done_in;
    logic        busy_out;
    logic        blob_valid_out;
    logic        blob_ready_in;
    logic [7:0]  blob_label_out;
    logic [8:0]  blob_x_out;
    logic [7:0]  blob_y_out;
    logic [15:0] blob_area_out;
    logic        frame_summary_out;
    logic [7:0]  num_blobs_out;
    logic        overflow_out;
`ifdef BLOB_BBOX_EN
    logic [8:0]  blob_xmin_out;
    logic [8:0]  blob_xmax_out;
    logic [7:0]  blob_ymin_out;
    logic [7:0]  blob_ymax_out;
`endif

    blob_stats dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .label_in          (label_in),
        .x_in              (x_in),
        .y_in              (y_in),
        .valid_in          (valid_in),
        .frame_done_in     (frame_done_in),
        .busy_out          (busy_out),
        .blob_valid_out    (blob_valid_out),
        .blob_ready_in     (blob_ready_in),
        .blob_label_out    (blob_label_out),
        .blob_x_out        (blob_x_out),
        .blob_y_out        (blob_y_out),
        .blob_area_out     (blob_area_out),
        .frame_summary_out (frame_summary_out),
        .num_blobs_out     (num_blobs_out),
        .overflow_out      (overflow_out)
`ifdef BLOB_BBOX_EN
        ,
        .blob_xmin_out     (blob_xmin_out),
        .blob_xmax_out     (blob_xmax_out),
        .blob_ymin_out     (blob_ymin_out),
        .blob_ymax_out     (blob_ymax_out)
`endif
    );

    typedef struct {
        int lbl; int x; int y; int area;
        int xmn; int xmx; int ymn; int ymx;
    } rec_t;

    rec_t exp_q[$];
    int   sum_q[$];
    rec_t mon_e;

    int checks   = 0;
    int failures = 0;

    int m_area[ML];
    int m_xs[ML];
    int m_ys[ML];
    int m_xmn[ML];
    int m_xmx[ML];
    int m_ymn[ML];
    int m_ymx[ML];
    bit m_ovf;

    bit rand_rdy  = 0;
    bit force_rdy = 1;

    initial begin
        clk_in = 0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic cycle();
        @(posedge clk_in);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < ML; i++) begin
            m_area[i] = 0; m_xs[i] = 0; m_ys[i] = 0;
            m_xmn[i] = 319; m_xmx[i] = 0; m_ymn[i] = 179; m_ymx[i] = 0;
        end
        m_ovf = 0;
    endtask

    task automatic model_add(input bit v, input int l, input int x, input int y);
        if (v && l >= ML) m_ovf = 1;
        if (v && l >= 1 && l < ML && x < 320 && y < 180) begin
            if (m_area[l] < 65535) m_area[l]++;
            m_xs[l] += x;
            m_ys[l] += y;
            if (x < m_xmn[l]) m_xmn[l] = x;
            if (x > m_xmx[l]) m_xmx[l] = x;
            if (y < m_ymn[l]) m_ymn[l] = y;
            if (y > m_ymx[l]) m_ymx[l] = y;
        end
    endtask

    task automatic set_pix(input bit v, input int l, input int x, input int y);
        valid_in = v;
        label_in = 8'(l);
        x_in     = 11'(x);
        y_in     = 10'(y);
        model_add(v, l, x, y);
    endtask

    task automatic drive_pix(input bit v, input int l, input int x, input int y);
        set_pix(v, l, x, y);
        cycle();
        valid_in = 0;
    endtask

    task automatic square(input int l, input int x0, input int y0, input int w, input int h);
        for (int yy = 0; yy < h; yy++)
            for (int xx = 0; xx < w; xx++)
                drive_pix(1, l, x0 + xx, y0 + yy);
    endtask

    // Blobs surviving pruning, in ascending label order, with truncated centroids.
    task automatic compute_expected(output int nexp);
        rec_t r;
        nexp = 0;
        for (int l = 1; l < ML; l++) begin
            if (m_area[l] >= 50) begin
                r.lbl = l; r.area = m_area[l];
                r.x = m_xs[l] / m_area[l];
                r.y = m_ys[l] / m_area[l];
                r.xmn = m_xmn[l]; r.xmx = m_xmx[l];
                r.ymn = m_ymn[l]; r.ymx = m_ymx[l];
                exp_q.push_back(r);
                nexp++;
            end
        end
        sum_q.push_back(nexp);
    endtask

    task automatic start_frame(input bit with_pix, output int nexp);
        if (with_pix)
            set_pix($urandom_range(0, 7) != 0, $urandom_range(0, 15),
                    $urandom_range(0, 325), $urandom_range(0, 183));
        else
            valid_in = 0;
        compute_expected(nexp);
        frame_done_in = 1;
        cycle();
        valid_in      = 0;
        frame_done_in = 0;
        chk("busy_rise", int'(busy_out), 1);
        chk("overflow_frame", int'(overflow_out), int'(m_ovf));
    endtask

    task automatic wait_frame(input int nexp, input bit junk);
        int n;
        int lat;
        n = 1;
        lat = 0;
        while (busy_out && n < 4000) begin
            if (frame_summary_out && lat == 0) lat = n;
            if (junk) begin
                valid_in      = 1;
                label_in      = 8'($urandom_range(1, 3));
                x_in          = 11'($urandom_range(0, 319));
                y_in          = 10'($urandom_range(0, 179));
                frame_done_in = ($urandom_range(0, 15) == 0);
            end
            cycle();
            n++;
        end
        valid_in      = 0;
        frame_done_in = 0;
        chk("frame_end_timeout", int'(busy_out), 0);
        if (nexp == 0) chk("empty_frame_latency", lat, ML);
        chk("overflow_cleared", int'(overflow_out), 0);
        chk("valid_after_frame", int'(blob_valid_out), 0);
        model_clear();
    endtask

    task automatic end_frame(input bit with_pix, input bit junk);
        int nexp;
        start_frame(with_pix, nexp);
        wait_frame(nexp, junk);
    endtask

    task automatic check_idle(input string nm);
        chk({nm, "_busy"},    int'(busy_out), 0);
        chk({nm, "_valid"},   int'(blob_valid_out), 0);
        chk({nm, "_summary"}, int'(frame_summary_out), 0);
        chk({nm, "_ovf"},     int'(overflow_out), 0);
        chk({nm, "_label"},   int'(blob_label_out), 0);
        chk({nm, "_x"},       int'(blob_x_out), 0);
        chk({nm, "_y"},       int'(blob_y_out), 0);
        chk({nm, "_area"},    int'(blob_area_out), 0);
        chk({nm, "_num"},     int'(num_blobs_out), 0);
`ifdef BLOB_BBOX_EN
        chk({nm, "_xmin"},    int'(blob_xmin_out), 0);
        chk({nm, "_xmax"},    int'(blob_xmax_out), 0);
        chk({nm, "_ymin"},    int'(blob_ymin_out), 0);
        chk({nm, "_ymax"},    int'(blob_ymax_out), 0);
`endif
    endtask

    initial begin
        blob_ready_in = 1;
        forever begin
            @(posedge clk_in);
            #1;
            blob_ready_in = rand_rdy ? ($urandom_range(0, 3) != 0) : force_rdy;
        end
    end

    // Monitor: while a record is offered it must match the scoreboard head; pop on handshake.
    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (blob_valid_out) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_record", int'(blob_label_out), -1);
                end else begin
                    mon_e = exp_q[0];
                    chk("rec_label", int'(blob_label_out), mon_e.lbl);
                    chk("rec_x",     int'(blob_x_out),     mon_e.x);
                    chk("rec_y",     int'(blob_y_out),     mon_e.y);
                    chk("rec_area",  int'(blob_area_out),  mon_e.area);
`ifdef BLOB_BBOX_EN
                    chk("rec_xmin",  int'(blob_xmin_out),  mon_e.xmn);
                    chk("rec_xmax",  int'(blob_xmax_out),  mon_e.xmx);
                    chk("rec_ymin",  int'(blob_ymin_out),  mon_e.ymn);
                    chk("rec_ymax",  int'(blob_ymax_out),  mon_e.ymx);
`endif
                    if (blob_ready_in) void'(exp_q.pop_front());
                end
            end
            if (frame_summary_out) begin
                if (sum_q.size() == 0) begin
                    chk("unexpected_summary", int'(num_blobs_out), -1);
                end else begin
                    chk("records_before_summary", exp_q.size(), 0);
                    chk("num_blobs", int'(num_blobs_out), sum_q.pop_front());
                end
            end
        end
    end

    initial begin
        int nexp;
        int n;
        rst_in = 1;
        valid_in = 0;
        frame_done_in = 0;
        label_in = 0;
        x_in = 0;
        y_in = 0;
        model_clear();
        repeat (3) cycle();
        rst_in = 0;
        check_idle("reset");

        // Single 10x10 square.
        square(3, 100, 50, 10, 10);
        end_frame(0, 0);

        // Area pruning boundary: 49 px dropped, 50 px kept.
        square(2, 10, 10, 7, 7);
        square(5, 200, 100, 10, 5);
        end_frame(0, 1);

        // Backpressure: first record held for 20 cycles with ready low.
        force_rdy = 0;
        square(4, 0, 0, 8, 8);
        square(9, 300, 170, 10, 10);
        start_frame(0, nexp);
        n = 0;
        while (!blob_valid_out && n < 200) begin
            cycle();
            n++;
        end
        chk("hold_valid_seen", int'(blob_valid_out), 1);
        repeat (20) cycle();
        chk("hold_still_valid", int'(blob_valid_out), 1);
        chk("hold_first_label", int'(blob_label_out), 4);
        force_rdy = 1;
        wait_frame(nexp, 0);

        // Excluded pixels: label 0, overflow label, out-of-range coordinates, valid low.
        square(6, 0, 0, 7, 7);
        drive_pix(1, 0, 10, 10);
        chk("ovf_label0", int'(overflow_out), 0);
        drive_pix(1, 6, 320, 0);
        drive_pix(1, 6, 0, 180);
        drive_pix(0, 6, 1, 1);
        chk("ovf_range", int'(overflow_out), 0);
        drive_pix(1, 20, 5, 5);
        chk("ovf_label20", int'(overflow_out), 1);
        end_frame(0, 0);

        // Reset while dividing aborts the frame.
        square(7, 20, 20, 8, 8);
        drive_pix(1, 20, 1, 1);
        frame_done_in = 1;
        cycle();
        frame_done_in = 0;
        repeat (12) cycle();
        chk("busy_mid_divide", int'(busy_out), 1);
        rst_in = 1;
        cycle();
        rst_in = 0;
        check_idle("rst_divide");
        model_clear();
        repeat (30) cycle();
        chk("no_record_after_rst", int'(blob_valid_out), 0);
        square(7, 40, 60, 10, 6);
        end_frame(0, 0);

        // Randomised frames with random ready and junk while busy.
        rand_rdy = 1;
        for (int f = 0; f < 6; f++) begin
            int np;
            int l;
            np = $urandom_range(400, 900);
            for (int p = 0; p < np; p++) begin
                l = ($urandom_range(0, 40) == 0) ? $urandom_range(16, 30) : $urandom_range(0, 15);
                drive_pix($urandom_range(0, 7) != 0, l, $urandom_range(0, 325), $urandom_range(0, 183));
            end
            end_frame($urandom_range(0, 1), 1);
        end
        rand_rdy = 0;
        repeat (3) cycle();

        chk("records_left", exp_q.size(), 0);
        chk("summaries_left", sum_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/blob_stats.md
# blob_stats

Streaming per-label statistics stage placed directly downstream of the connected-component labeller. It consumes the resolved label stream, one pixel per cycle, and accumulates area, coordinate sums and optional bounding boxes for each label. On frame end it drops blobs smaller than `MIN_AREA`, divides the sums with an internal sequential divider to get centroids, and emits one record per surviving blob over a valid/ready handshake. The tracking/overlay logic consumes those records.

## Interface
- `WIDTH`, 320, horizontal resolution; pixels with `x_in >= WIDTH` are dropped
- `HEIGHT`, 180, vertical resolution; pixels with `y_in >= HEIGHT` are dropped
- `MAX_LABELS`, 16, table entries; label 0 is background, labels 1..MAX_LABELS-1 are tracked
- `MIN_AREA`, 50, blobs with `area < MIN_AREA` are pruned
- `clk_in` in 1: single clock
- `rst_in` in 1: synchronous, active-high reset
- `label_in` in 8: resolved label of the current pixel
- `x_in` in 11: pixel column
- `y_in` in 10: pixel row
- `valid_in` in 1: pixel qualifier
- `frame_done_in` in 1: one-cycle pulse after the last pixel of a frame
- `busy_out` out 1: high from frame end until the summary pulse; input is ignored while high
- `blob_valid_out` out 1: record valid
- `blob_ready_in` in 1: consumer accepts the record
- `blob_label_out` out 8: label of the record
- `blob_x_out` out 9: centroid column
- `blob_y_out` out 8: centroid row
- `blob_area_out` out 16: pixel count, saturating
- `frame_summary_out` out 1: one-cycle pulse after the last record
- `num_blobs_out` out 8: number of surviving blobs, valid with `frame_summary_out`
- `overflow_out` out 1: sticky per frame; set by any valid pixel with `label_in >= MAX_LABELS`

## Operation
- States: ACCUM, SCAN, DIVIDE, EMIT, DONE, CLEAR.
- ACCUM (state after reset)
  - A pixel counts only when `valid_in` is high, `label_in` is in 1..MAX_LABELS-1, `x_in < WIDTH` and `y_in < HEIGHT`.
  - For a counted pixel L: `area[L]++` saturating at 16'hFFFF, `xsum[L] += x_in`, `ysum[L] += y_in`, and `present[L] = 1`.
  - Sums are 26 bits and cannot overflow within one frame.
- Frame end
  - `frame_done_in` moves the block to SCAN with scan index 1 and raises `busy_out`.
  - If a counted pixel arrives in the same cycle as `frame_done_in`, that pixel is accumulated first.
- SCAN (one cycle per index)
  - If `present[i]` and `area[i] >= MIN_AREA`: go to DIVIDE.
  - Otherwise: increment i.
  - After the index MAX_LABELS-1 has been checked: go to DONE.
- DIVIDE
  - Restoring divide, one quotient bit per cycle, 26 iterations.
  - `xsum/area` and `ysum/area` are computed in parallel.
  - Quotients are truncated. They are provably below WIDTH/HEIGHT and are narrowed to the output widths.
  - When done: go to EMIT.
- EMIT
  - Present the record with `blob_valid_out = 1`.
  - Outputs are held stable while `blob_ready_in` is low.
  - On `valid && ready`: increment the blob count and i, return to SCAN.
- DONE: pulse `frame_summary_out` and drive `num_blobs_out` for exactly one cycle, then go to CLEAR.
- CLEAR: zero all table entries and `overflow_out` in one cycle, drop `busy_out`, return to ACCUM.

## Timing
- Reset values: `busy_out = 0`, `blob_valid_out = 0`, `frame_summary_out = 0`, `overflow_out = 0`, and every data output is 0. Reset also clears the table.
- Reset takes effect in any state, including mid-DIVIDE or mid-EMIT. No record is emitted after reset.
- Accumulation accepts one pixel per cycle with no stall. Table update has a 1-cycle latency; back-to-back pixels of the same label accumulate correctly.
- `busy_out` rises the cycle after `frame_done_in` and falls the cycle after CLEAR.
- Per-blob latency with `blob_ready_in` held high: 1 SCAN cycle + 26 DIVIDE cycles + 1 EMIT cycle.
- Frame with zero blobs: `frame_summary_out` fires `MAX_LABELS` cycles after `frame_done_in`.
- `frame_done_in` while busy is ignored.
- Pixels arriving while busy are dropped. The upstream stage must hold off until `busy_out` falls.

## Configuration
- `BLOB_BBOX_EN` defined:
  - Per label, track `xmin`, `xmax`, `ymin`, `ymax`. Reset/clear values are xmin = WIDTH-1, ymin = HEIGHT-1, xmax = ymax = 0.
  - Extra outputs `blob_xmin_out`/`blob_xmax_out` (9 bits) and `blob_ymin_out`/`blob_ymax_out` (8 bits) are emitted with each record and reset to 0.
- `BLOB_BBOX_EN` undefined: no bounding-box storage and no bbox ports; all other behaviour is identical.

## Test plan
- 10x10 square of label 3 at x 100..109, y 50..59, then `frame_done_in`, ready high -> one record: label 3, x 104, y 54, area 100; then `frame_summary_out` with `num_blobs_out = 1`.
- Label 2 with 49 px plus label 5 with 50 px -> only label 5 emitted; `num_blobs_out = 1`.
- Two qualifying blobs with `blob_ready_in` low for 20 cycles -> record 1 held stable for 20 cycles, then labels emitted in ascending order.
- Pixels with label 0, label 20 and x 320 -> none counted; `overflow_out = 1` only for label 20; `overflow_out` cleared after CLEAR.
- `rst_in` pulsed during DIVIDE -> all outputs 0, ACCUM state; next frame statistics are correct.
- With `BLOB_BBOX_EN`, the square from test 1 -> bbox 100/109/50/59.
